window_sn_writer: RTL and testbench



---
 rtl/codec2_pkg.sv | 9 +
 rtl/qmult.sv | 22 ++
 rtl/window_sn_writer.sv | 136 +++++++++++++
 tb/tb_window_sn_writer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/codec2_pkg.sv
// Shared CODEC2 encoder constants: data format, frame size and address width.
package codec2_pkg;
  localparam int unsigned N     = 32;
  localparam int unsigned Q     = 16;
  localparam int unsigned NSAM  = 320;
  localparam int unsigned AW    = 9;
  localparam int unsigned ORDER = 10;
  localparam logic [N-1:0] ONE  = 32'h0001_0000;
endpackage

// File: rtl/qmult.sv
// Sign-magnitude fixed-point multiplier; magnitude product truncated to N bits.
module qmult #(
  parameter int unsigned Q = 16,
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result
);
  localparam int unsigned PW = 2 * N - 2;

  logic [PW-1:0] prod;
  logic          unused_bits;

  always_comb begin
    prod   = PW'(a[N-2:0]) * PW'(b[N-2:0]);
    result = {a[N-1] ^ b[N-1], prod[N-2+Q:Q]};
  end

  // Integer overflow and sub-LSB fraction bits are dropped by design.
  assign unused_bits = ^{prod[PW-1:N-1+Q], prod[Q-1:0]};
endmodule

// File: rtl/window_sn_writer.sv
// Windows one frame of speech samples into the Sn RAM, one sample at a time,
// issuing reads for sample i+1 only after sample i has been written.
module window_sn_writer
  import codec2_pkg::*;
#(
  parameter int unsigned RD_LAT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          startwn,
  input  logic [N-1:0]  speech_read_data,
  input  logic [N-1:0]  w_read_data,
  output logic [AW-1:0] speech_addr,
  output logic [AW-1:0] w_addr,
  output logic [AW-1:0] wn_addr,
  output logic [N-1:0]  wn_write_data,
  output logic          wn_wren,
  output logic          donewn
);
  localparam int unsigned CW = $clog2(NSAM + 1);
  localparam int unsigned WW = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  localparam logic [3:0] S_START    = 4'd0;
  localparam logic [3:0] S_INIT     = 4'd1;
  localparam logic [3:0] S_SET_ADDR = 4'd2;
  localparam logic [3:0] S_WAIT     = 4'd3;
  localparam logic [3:0] S_CAPTURE  = 4'd4;
  localparam logic [3:0] S_MULT     = 4'd5;
  localparam logic [3:0] S_WRITE    = 4'd6;
  localparam logic [3:0] S_CHECK    = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  logic [3:0]    state, state_nxt;
  logic [CW-1:0] i, i_nxt;
  logic [WW-1:0] wait_cnt, wait_cnt_nxt;
  logic [N-1:0]  op_s, op_s_nxt;
  logic [N-1:0]  op_w, op_w_nxt;
  logic [N-1:0]  prod;
  logic [AW-1:0] speech_addr_nxt, w_addr_nxt, wn_addr_nxt;
  logic [N-1:0]  wn_write_data_nxt;
  logic          wn_wren_nxt, donewn_nxt;

  qmult #(.Q(Q), .N(N)) u_qmult (
    .a      (op_s),
    .b      (op_w),
    .result (prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_START;
      i             <= '0;
      wait_cnt      <= '0;
      op_s          <= '0;
      op_w          <= '0;
      speech_addr   <= '0;
      w_addr        <= '0;
      wn_addr       <= '0;
      wn_write_data <= '0;
      wn_wren       <= 1'b0;
      donewn        <= 1'b0;
    end else begin
      state         <= state_nxt;
      i             <= i_nxt;
      wait_cnt      <= wait_cnt_nxt;
      op_s          <= op_s_nxt;
      op_w          <= op_w_nxt;
      speech_addr   <= speech_addr_nxt;
      w_addr        <= w_addr_nxt;
      wn_addr       <= wn_addr_nxt;
      wn_write_data <= wn_write_data_nxt;
      wn_wren       <= wn_wren_nxt;
      donewn        <= donewn_nxt;
    end
  end

  // Next-state and next-output logic; every register holds unless its state updates it.
  always_comb begin
    state_nxt         = state;
    i_nxt             = i;
    wait_cnt_nxt      = wait_cnt;
    op_s_nxt          = op_s;
    op_w_nxt          = op_w;
    speech_addr_nxt   = speech_addr;
    w_addr_nxt        = w_addr;
    wn_addr_nxt       = wn_addr;
    wn_write_data_nxt = wn_write_data;
    wn_wren_nxt       = wn_wren;
    donewn_nxt        = donewn;
    case (state)
      S_START: begin
        if (startwn) state_nxt = S_INIT;
      end
      S_INIT: begin
        i_nxt      = '0;
        donewn_nxt = 1'b0;
        state_nxt  = S_SET_ADDR;
      end
      S_SET_ADDR: begin
        speech_addr_nxt = AW'(i);
        w_addr_nxt      = AW'(i);
        wait_cnt_nxt    = '0;
        state_nxt       = (RD_LAT > 1) ? S_WAIT : S_CAPTURE;
      end
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) state_nxt = S_CAPTURE;
        else wait_cnt_nxt = wait_cnt + WW'(1);
      end
      S_CAPTURE: begin
        op_s_nxt  = speech_read_data;
        op_w_nxt  = w_read_data;
        state_nxt = S_MULT;
      end
      S_MULT: begin
        wn_write_data_nxt = prod;
        wn_addr_nxt       = AW'(i);
        wn_wren_nxt       = 1'b1;
        state_nxt         = S_WRITE;
      end
      S_WRITE: begin
        wn_wren_nxt = 1'b0;
        i_nxt       = i + CW'(1);
        state_nxt   = S_CHECK;
      end
      S_CHECK: begin
        state_nxt = (i < CW'(NSAM)) ? S_SET_ADDR : S_DONE;
      end
      S_DONE: begin
        donewn_nxt = 1'b1;
        state_nxt  = S_START;
      end
      default: state_nxt = S_START;
    endcase
  end
endmodule

// File: tb/tb_window_sn_writer.sv
// Bench for window_sn_writer: RD_LAT=3 and RD_LAT=1 instances share stimulus and
// are checked every cycle against a frame-level timing and arithmetic model.
module tb_window_sn_writer;
  import codec2_pkg::*;

  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic startwn = 1'b0;

  logic [N-1:0] speech_mem [512];
  logic [N-1:0] w_mem [512];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned LAT = (g == 0) ? 3 : 1;
    logic [AW-1:0] sa, wa, wna;
    logic [N-1:0]  srd, wrd, wd;
    logic          wren, dn;

    if (LAT == 1) begin : g_comb
      assign srd = speech_mem[sa];
      assign wrd = w_mem[wa];
    end else begin : g_pipe
      logic [AW-1:0] s_hist [LAT-1];
      logic [AW-1:0] w_hist [LAT-1];
      always_ff @(posedge clk) begin
        s_hist[0] <= sa;
        w_hist[0] <= wa;
        for (int k = 1; k < int'(LAT) - 1; k++) begin
          s_hist[k] <= s_hist[k-1];
          w_hist[k] <= w_hist[k-1];
        end
      end
      assign srd = speech_mem[s_hist[LAT-2]];
      assign wrd = w_mem[w_hist[LAT-2]];
    end

    window_sn_writer #(.RD_LAT(LAT)) u_dut (
      .clk              (clk),
      .rst              (rst),
      .startwn          (startwn),
      .speech_read_data (srd),
      .w_read_data      (wrd),
      .speech_addr      (sa),
      .w_addr           (wa),
      .wn_addr          (wna),
      .wn_write_data    (wd),
      .wn_wren          (wren),
      .donewn           (dn)
    );
  end

  int errors = 0;
  int checks = 0;
  int e = 0;
  bit busy [NI] = '{0, 0};
  bit done_exp [NI] = '{0, 0};
  bit prev_dn [NI] = '{0, 0};
  int s [NI] = '{0, 0};
  int nwr [NI] = '{0, 0};
  int rise_at [NI] = '{-1, -1};
  logic [N-1:0] sn_ram [NI][512];

  function automatic int lat_of(input int g);
    return (g == 0) ? 3 : 1;
  endfunction

  // Q16.16 sign-magnitude product: sign is the XOR, magnitude is |a|*|b| >> 16.
  function automatic logic [N-1:0] qref(input logic [N-1:0] a, input logic [N-1:0] b);
    longint unsigned ma, mb, mag;
    ma  = longint'(a[30:0]);
    mb  = longint'(b[30:0]);
    mag = (ma * mb) >> 16;
    return {a[31] ^ b[31], mag[30:0]};
  endfunction

  task automatic chk(input string name, input int g, input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d edge=%0d: got %08h want %08h", name, g, e, act, exp);
    end
  endtask

  // One clock: advance past the edge, then step the model and compare on the falling edge.
  task automatic tick();
    logic          ow [NI];
    logic          od [NI];
    logic [AW-1:0] oa [NI];
    logic [N-1:0]  owd [NI];
    @(posedge clk);
    @(negedge clk);
    e++;
    ow[0] = g_inst[0].wren; od[0] = g_inst[0].dn; oa[0] = g_inst[0].wna; owd[0] = g_inst[0].wd;
    ow[1] = g_inst[1].wren; od[1] = g_inst[1].dn; oa[1] = g_inst[1].wna; owd[1] = g_inst[1].wd;
    for (int g = 0; g < NI; g++) begin
      int  lat, per, d, k;
      bit  exp_wr;
      lat    = lat_of(g);
      per    = lat + 4;
      exp_wr = 1'b0;
      k      = 0;
      if (rst) begin
        busy[g]     = 1'b0;
        done_exp[g] = 1'b0;
      end else if (!busy[g]) begin
        if (startwn) begin
          busy[g] = 1'b1;
          s[g]    = e;
          nwr[g]  = 0;
        end
      end else begin
        d = e - s[g] - 3 - lat;
        if (e == s[g] + 1) done_exp[g] = 1'b0;
        if (d >= 0 && (d % per) == 0 && (d / per) < int'(NSAM)) begin
          exp_wr = 1'b1;
          k      = d / per;
        end
        if (e == s[g] + 2 + int'(NSAM) * per) begin
          done_exp[g] = 1'b1;
          busy[g]     = 1'b0;
        end
      end
      chk("wn_wren", g, N'(ow[g]), N'(exp_wr));
      chk("donewn", g, N'(od[g]), N'(done_exp[g]));
      if (exp_wr && ow[g]) begin
        chk("wn_addr", g, N'(oa[g]), N'(k));
        chk("wn_write_data", g, owd[g], qref(speech_mem[k], w_mem[k]));
      end
      if (ow[g] === 1'b1) begin
        sn_ram[g][oa[g]] = owd[g];
        nwr[g]++;
      end
      if (od[g] === 1'b1 && !prev_dn[g]) rise_at[g] = e - s[g];
      prev_dn[g] = (od[g] === 1'b1);
    end
  endtask

  task automatic pulse_start();
    startwn = 1'b1;
    tick();
    startwn = 1'b0;
  endtask

  task automatic wait_done();
    int c;
    repeat (2) tick();
    c = 0;
    while (!(g_inst[0].dn === 1'b1 && g_inst[1].dn === 1'b1) && c < 3000) begin
      tick();
      c++;
    end
    checks++;
    if (c >= 3000) begin
      errors++;
      $display("FAIL donewn_timeout: got no donewn within %0d cycles want donewn=1", c);
    end
    repeat (3) tick();
  endtask

  initial begin
    // Frame 1: unit window, ramp speech.
    for (int i = 0; i < 512; i++) begin
      speech_mem[i] = 32'(i) << 16;
      w_mem[i]      = ONE;
    end
    tick();
    tick();
    chk("reset_speech_addr", 0, N'(g_inst[0].sa), 32'h0);
    chk("reset_w_addr", 0, N'(g_inst[0].wa), 32'h0);
    chk("reset_wn_addr", 1, N'(g_inst[1].wna), 32'h0);
    chk("reset_wn_data", 1, g_inst[1].wd, 32'h0);
    rst = 1'b0;
    tick();

    pulse_start();
    wait_done();
    for (int g = 0; g < NI; g++) chk("write_count_f1", g, N'(nwr[g]), N'(NSAM));
    chk("done_edge_lat3", 0, N'(rise_at[0]), 32'd2242);
    chk("done_edge_lat1", 1, N'(rise_at[1]), 32'd1602);
    chk("ram5_f1", 0, sn_ram[0][5], 32'h0005_0000);
    chk("ram319_f1", 1, sn_ram[1][319], 32'h013F_0000);

    // Frame 2: half window, constant 4.0 speech, one negative sample; extra start mid-frame.
    for (int i = 0; i < 512; i++) begin
      speech_mem[i] = 32'h0004_0000;
      w_mem[i]      = 32'h0000_8000;
    end
    speech_mem[5] = 32'h8003_0000;
    rise_at = '{-1, -1};
    pulse_start();
    repeat (2 + 100 * 7) tick();
    pulse_start();
    wait_done();
    for (int g = 0; g < NI; g++) begin
      chk("write_count_f2", g, N'(nwr[g]), N'(NSAM));
      chk("ram5_neg", g, sn_ram[g][5], 32'h8001_8000);
      chk("ram17_half", g, sn_ram[g][17], 32'h0002_0000);
    end
    chk("done_edge_restart_ignored", 0, N'(rise_at[0]), 32'd2242);

    // Frame 3: mixed-sign data, reset during sample 150, then a full restart.
    for (int i = 0; i < 512; i++) begin
      speech_mem[i] = (32'(i) * 32'h0001_3579) ^ (((i % 3) == 0) ? 32'h8000_0000 : 32'h0);
      w_mem[i]      = (32'h0000_4000 + 32'(i) * 32'd97) | (((i % 5) == 0) ? 32'h8000_0000 : 32'h0);
    end
    pulse_start();
    repeat (2 + 150 * 7 + 2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("writes_before_reset", 0, N'(nwr[0]), 32'd150);
    chk("donewn_after_reset", 0, N'(g_inst[0].dn), 32'h0);
    tick();
    rise_at = '{-1, -1};
    pulse_start();
    wait_done();
    for (int g = 0; g < NI; g++) chk("write_count_f3", g, N'(nwr[g]), N'(NSAM));
    chk("done_edge_after_reset", 0, N'(rise_at[0]), 32'd2242);
    chk("ram3_mixed", 0, sn_ram[0][3], qref(32'h8003_A06B, 32'h0000_4123));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
